// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic engines: default
// parameters, the exponentiation FSM state encoding and exponent helpers.
package mod_arith_pkg;

  localparam int DEF_P_WIDTH  = 16;
  localparam int DEF_MODULUS  = 4591;
  localparam int DEF_EXP_BITS = 13;
  localparam int DEF_MUL_LAT  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_DONE
  } state_e;

  // Fermat's little theorem: for prime q, x^(q-2) is the inverse of x.
  function automatic int inv_exp(input int q);
    return q - 2;
  endfunction

endpackage

// File: rtl/mod_mult_pipe.sv
// Pipelined modular multiplier: (a*b) mod MODULUS appears on p with v_out
// exactly MUL_LAT cycles after a, b and v_in are presented.
module mod_mult_pipe #(
  parameter int P_WIDTH = 16,
  parameter int MODULUS = 4591,
  parameter int MUL_LAT = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  input  logic               v_in,
  output logic [P_WIDTH-1:0] p,
  output logic               v_out
);

  logic [2*P_WIDTH-1:0] fullProd;
  logic [P_WIDTH-1:0]   modProd;
  logic [P_WIDTH-1:0]   stageData_q [MUL_LAT];
  logic [MUL_LAT-1:0]   stageVld_q;

  assign fullProd = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
  assign modProd  = P_WIDTH'(fullProd % (2*P_WIDTH)'(MODULUS));

  // Reduced product enters the first stage, then ripples down the delay line.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        stageData_q[i] <= '0;
      end
      stageVld_q <= '0;
    end else begin
      stageData_q[0] <= modProd;
      stageVld_q[0]  <= v_in;
      for (int i = 1; i < MUL_LAT; i++) begin
        stageData_q[i] <= stageData_q[i-1];
        stageVld_q[i]  <= stageVld_q[i-1];
      end
    end
  end

  assign p     = stageData_q[MUL_LAT-1];
  assign v_out = stageVld_q[MUL_LAT-1];

endmodule

// File: rtl/mod_pow_inverse.sv
// Constant-time modular exponentiation: inverse (In^(Q-2)) or general power
// (In^Exp) mod a prime Q, left-to-right square-and-always-multiply.
module mod_pow_inverse
  import mod_arith_pkg::*;
#(
  parameter int P_WIDTH  = DEF_P_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int EXP_BITS = DEF_EXP_BITS,
  parameter int MUL_LAT  = DEF_MUL_LAT
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Mode,
  input  logic [P_WIDTH-1:0]  In,
  input  logic [EXP_BITS-1:0] Exp,
  output logic                Busy,
  output logic [P_WIDTH-1:0]  Out,
  output logic                Valid,
  output logic                Err
);

  localparam int IDX_W  = $clog2(EXP_BITS);
  localparam int WAIT_W = $clog2(MUL_LAT + 1);

  localparam logic [P_WIDTH-1:0]  Q_VAL     = P_WIDTH'(MODULUS);
  localparam logic [EXP_BITS-1:0] INV_E     = EXP_BITS'(inv_exp(MODULUS));
  localparam logic [IDX_W-1:0]    TOP_IDX   = IDX_W'(EXP_BITS - 1);
  localparam logic [WAIT_W-1:0]   LAST_WAIT = WAIT_W'(MUL_LAT);

  state_e              state_q, state_d;
  logic [P_WIDTH-1:0]  acc_q, acc_d;
  logic [P_WIDTH-1:0]  base_q, base_d;
  logic [EXP_BITS-1:0] e_q, e_d;
  logic [IDX_W-1:0]    bitIdx_q, bitIdx_d;
  logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
  logic                opErr_q, opErr_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [P_WIDTH-1:0]  out_q, out_d;

  logic               accept;
  logic               phaseDone;
  logic               mulVin;
  logic [P_WIDTH-1:0] mulB;
  logic [P_WIDTH-1:0] mulP;
  logic               mulVld;

  assign accept    = Start && !busy_q;
  assign phaseDone = (waitCnt_q == LAST_WAIT) && mulVld;

  mod_mult_pipe #(
    .P_WIDTH(P_WIDTH),
    .MODULUS(MODULUS),
    .MUL_LAT(MUL_LAT)
  ) u_mult (
    .Clk  (Clk),
    .Reset(Reset),
    .a    (acc_q),
    .b    (mulB),
    .v_in (mulVin),
    .p    (mulP),
    .v_out(mulVld)
  );

  // Next-state logic: each phase issues one product, waits for it, then
  // commits; the multiply phase always runs so timing is operand-independent.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    base_d    = base_q;
    e_d       = e_q;
    bitIdx_d  = bitIdx_q;
    waitCnt_d = waitCnt_q;
    opErr_d   = opErr_q;
    busy_d    = 1'b1;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    out_d     = out_q;
    mulVin    = 1'b0;
    mulB      = acc_q;
    case (state_q)
      S_IDLE: begin
        busy_d = accept;
        if (accept) begin
          base_d    = In;
          e_d       = Mode ? Exp : INV_E;
          acc_d     = P_WIDTH'(1);
          bitIdx_d  = TOP_IDX;
          waitCnt_d = '0;
          opErr_d   = (In >= Q_VAL) || (!Mode && (In == '0));
          state_d   = S_SQR;
        end
      end
      S_SQR: begin
        mulVin = (waitCnt_q == '0);
        if (phaseDone) begin
          acc_d     = mulP;
          waitCnt_d = '0;
          state_d   = S_MUL;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      S_MUL: begin
        mulB   = base_q;
        mulVin = (waitCnt_q == '0);
        if (phaseDone) begin
          if (e_q[bitIdx_q]) begin
            acc_d = mulP;
          end
          waitCnt_d = '0;
          if (bitIdx_q == '0) begin
            state_d = S_DONE;
          end else begin
            bitIdx_d = bitIdx_q - IDX_W'(1);
            state_d  = S_SQR;
          end
        end else begin
          waitCnt_d = waitCnt_q + WAIT_W'(1);
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        err_d   = opErr_q;
        out_d   = opErr_q ? '0 : acc_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      base_q    <= '0;
      e_q       <= '0;
      bitIdx_q  <= '0;
      waitCnt_q <= '0;
      opErr_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      e_q       <= e_d;
      bitIdx_q  <= bitIdx_d;
      waitCnt_q <= waitCnt_d;
      opErr_q   <= opErr_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      out_q     <= out_d;
    end
  end

  assign Busy  = busy_q;
  assign Valid = valid_q;
  assign Err   = err_q;
  assign Out   = out_q;

endmodule

// File: tb/tb_mod_pow_inverse.sv
// Self-checking bench for mod_pow_inverse: an arithmetic reference model is
// compared against the outputs every cycle, plus directed literal checks.
module tb_mod_pow_inverse;

  localparam int Q    = 4591;
  localparam int EB   = 13;
  localparam int ML   = 3;
  localparam int LAT  = 1 + 2*EB*(ML+1);
  localparam int Q2   = 7681;
  localparam int ML2  = 1;
  localparam int LAT2 = 1 + 2*EB*(ML2+1);

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start, Mode;
  logic [15:0] In;
  logic [12:0] Exp;
  logic        Busy, Valid, Err;
  logic [15:0] Out;

  logic        s2Start;
  logic [15:0] s2In;
  logic        s2Busy, s2Valid, s2Err;
  logic [15:0] s2Out;

  int checks = 0;
  int passed = 0;
  bit checkEn = 1'b0;

  always #5 Clk = ~Clk;

  mod_pow_inverse #(.P_WIDTH(16), .MODULUS(Q), .EXP_BITS(EB), .MUL_LAT(ML)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .In(In), .Exp(Exp),
    .Busy(Busy), .Out(Out), .Valid(Valid), .Err(Err)
  );

  mod_pow_inverse #(.P_WIDTH(16), .MODULUS(Q2), .EXP_BITS(EB), .MUL_LAT(ML2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(s2Start), .Mode(1'b0), .In(s2In), .Exp(13'd0),
    .Busy(s2Busy), .Out(s2Out), .Valid(s2Valid), .Err(s2Err)
  );

  function automatic longint modPow(input longint b, input longint e, input longint q);
    longint r = 1;
    longint x = b % q;
    longint k = e;
    while (k > 0) begin
      if ((k % 2) == 1) r = (r * x) % q;
      x = (x * x) % q;
      k = k / 2;
    end
    return r % q;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: a request is taken when idle, the answer appears LAT
  // cycles later for one cycle, and the bench's own modPow gives the value.
  bit     mBusy = 0, mValid = 0, mErr = 0, mResErr = 0;
  longint mOut = 0, mRes = 0;
  int     mCnt = 0;

  always @(posedge Clk) begin
    if (Reset) begin
      mBusy = 0; mValid = 0; mErr = 0; mOut = 0; mCnt = 0;
    end else if (mValid) begin
      mValid = 0; mBusy = 0;
    end else if (mBusy) begin
      mCnt--;
      if (mCnt == 0) begin
        mValid = 1; mOut = mRes; mErr = mResErr;
      end
    end else if (Start) begin
      mBusy   = 1;
      mCnt    = LAT;
      mResErr = (In >= Q) || (!Mode && In == 0);
      mRes    = mResErr ? 0 : modPow(In, Mode ? longint'(Exp) : longint'(Q-2), Q);
    end
  end

  // Compare the DUT with the model on every falling edge outside reset.
  always @(negedge Clk) begin
    if (checkEn && !Reset) begin
      checkOutput("busy", Busy, mBusy);
      checkOutput("valid", Valid, mValid);
      checkOutput("out", Out, mOut);
      if (mValid) checkOutput("err", Err, mErr);
    end
  end

  task automatic applyStimulus(input bit m, input int inV, input int expV,
                               input int wantOut, input bit wantErr, input string tag);
    int  n;
    bit  got;
    @(posedge Clk); #2;
    Start = 1'b1; Mode = m; In = 16'(inV); Exp = 13'(expV);
    @(posedge Clk); #2;
    Start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 2000) begin
      @(posedge Clk); n++; #1;
      if (Valid) got = 1;
    end
    checkOutput({tag, "_done"}, got, 1);
    checkOutput({tag, "_lat"}, n, LAT);
    checkOutput({tag, "_out"}, Out, wantOut);
    checkOutput({tag, "_err"}, Err, wantErr);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (Busy && n < 400) begin
      @(posedge Clk); #2; n++;
    end
    checkOutput({tag, "_idle"}, Busy, 0);
  endtask

  task automatic applyInv2(input int inV);
    int n;
    bit got;
    @(posedge Clk); #2;
    s2Start = 1'b1; s2In = 16'(inV);
    @(posedge Clk); #2;
    s2Start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 1000) begin
      @(posedge Clk); n++; #1;
      if (s2Valid) got = 1;
    end
    checkOutput("q2_done", got, 1);
    checkOutput("q2_lat", n, LAT2);
    checkOutput("q2_prod", (longint'(inV) * longint'(s2Out)) % Q2, 1);
    checkOutput("q2_err", s2Err, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vCount;
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; In = '0; Exp = '0;
    s2Start = 1'b0; s2In = '0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_valid", Valid, 0);
    checkOutput("rst_out", Out, 0);
    checkOutput("rst_err", Err, 0);
    #1;
    Reset = 1'b0;
    checkEn = 1'b1;

    // Pin the reference arithmetic itself.
    checkOutput("model_inv2", modPow(2, Q-2, Q), 2296);
    checkOutput("model_inv3", modPow(3, Q-2, Q), 3061);
    checkOutput("model_pow", modPow(5, 3, Q), 125);

    // Inverses and error cases.
    applyStimulus(0, 2, 0, 2296, 0, "inv2");
    applyStimulus(0, 3, 0, 3061, 0, "inv3");
    applyStimulus(0, 4590, 0, 4590, 0, "invm1");
    applyStimulus(0, 1, 0, 1, 0, "inv1");
    applyStimulus(0, 0, 0, 0, 1, "inv0");
    applyStimulus(0, 4591, 0, 0, 1, "invq");

    // General power.
    applyStimulus(1, 5, 3, 125, 0, "pow53");
    applyStimulus(1, 7, 0, 1, 0, "pow70");
    applyStimulus(1, 0, 4, 0, 0, "pow04");

    // Reset while squaring: operation is dropped, outputs cleared.
    applyStimulus(0, 2, 0, 2296, 0, "pre_rst");
    @(posedge Clk); #2;
    Start = 1'b1; Mode = 1'b0; In = 16'd3;
    @(posedge Clk); #2;
    Start = 1'b0;
    @(posedge Clk); #2;
    Reset = 1'b1;
    @(posedge Clk); #2;
    Reset = 1'b0;
    #1;
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_valid", Valid, 0);
    checkOutput("abort_out", Out, 0);
    vCount = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge Clk); #1;
      if (Valid) vCount++;
    end
    checkOutput("abort_novalid", vCount, 0);
    applyStimulus(0, 3, 0, 3061, 0, "post_rst");

    // Start held high with a changing operand: only idle-time requests count.
    @(posedge Clk); #2;
    Start = 1'b1; Mode = 1'b0; In = 16'd2;
    vCount = 0;
    for (int i = 0; i < 213; i++) begin
      @(posedge Clk); #2;
      if (Valid) begin
        vCount++;
        if (i == 105) checkOutput("held_first", Out, 2296);
        if (i == 212) checkOutput("held_second", Out, 3061);
      end
      In = (i % 2 == 0) ? 16'd3 : 16'd5;
    end
    Start = 1'b0;
    checkOutput("held_count", vCount, 2);
    waitIdle("held");

    // Second instance: other modulus, single-cycle multiplier.
    applyInv2(Q2 - 1);
    for (int i = 0; i < 12; i++) begin
      applyInv2(int'($urandom_range(1, Q2 - 1)));
    end

    repeat (3) @(posedge Clk);
    #1;
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
